uart_tx_sched: RTL and testbench

- Scheduler between the UART transmit FIFO (read side) and the UART transmitter byte interface.
- Waits for data in the FIFO and spaces pops to respect the FIFO's two-cycle read-pointer/flag update latency.
- Captures each head byte, pops it, and presents it to the transmitter with a valid/ready handshake.
- Supports enable, flush (drain without transmitting), a programmable inter-byte gap and a transmitted-byte counter.

---
 rtl/uart_tx_sched.sv | 86 ++++++++
 tb/tb_uart_tx_sched.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: paces pops from the UART TX FIFO around its flag latency and hands each byte to the transmitter
module uart_tx_sched #(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int TX_GAP        = 0,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  ENABLE,
  input  logic                  FLUSH,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_DATA,
  output logic                  FIFO_POP,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic [CNT_WIDTH-1:0]  SENT_COUNT
);
  typedef enum logic [1:0] {IDLE, SETTLE, POP, SEND} state_t;
  localparam logic [4:0] SETTLE_LD = 5'(SETTLE_CYCLES);
  localparam logic [4:0] GAP_LD    = 5'(SETTLE_CYCLES + TX_GAP);
  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  sent_q, sent_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE:
        if ((ENABLE || FLUSH) && !FIFO_EMPTY) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end
      SETTLE: begin
        cnt_d = cnt_q - 5'd1;
        // FIFO flags are only trusted once the settle window has elapsed
        if (cnt_q == 5'd1) state_d = (FIFO_EMPTY || (!ENABLE && !FLUSH)) ? IDLE : POP;
      end
      POP: begin
        data_d = FIFO_DATA;
        if (FLUSH) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          state_d = SEND;
          valid_d = 1'b1;
        end
      end
      SEND:
        if (TX_READY) begin
          state_d = SETTLE;
          cnt_d   = GAP_LD;
          valid_d = 1'b0;
          sent_d  = sent_q + CNT_WIDTH'(1);
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sent_q  <= sent_d;
    end
  end
  assign FIFO_POP   = state_q == POP;
  assign BUSY       = state_q != IDLE;
  assign TX_DATA    = data_q;
  assign TX_VALID   = valid_q;
  assign SENT_COUNT = sent_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: FIFO model plus byte scoreboard around uart_tx_sched
module tb_uart_tx_sched;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enable = 1'b0, flush = 1'b0, tx_ready = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = '0;
  logic        fifo_pop, tx_valid, busy;
  logic [7:0]  tx_data;
  logic [15:0] sent_count;
  logic [7:0]  fq[$];
  logic [7:0]  exp_q[$];
  int          pop_times[$];
  int          total = 0, bad = 0, cyc = 0, pops = 0, vcnt = 0, last_pop = -100;
  int          p0, v0, c_rel;

  uart_tx_sched dut (
    .CLK(clk), .RESETn(rst_n), .ENABLE(enable), .FLUSH(flush),
    .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data), .FIFO_POP(fifo_pop),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .BUSY(busy), .SENT_COUNT(sent_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // FIFO flags and head data are registered, so they trail a pop by one edge
  always @(posedge clk) begin
    cyc++;
    if (fifo_pop) begin
      if (fq.size() == 0) chk("pop_on_empty", 32'(fq.size()), 1);
      else void'(fq.pop_front());
    end
    fifo_empty <= fq.size() == 0;
    fifo_data  <= fq.size() != 0 ? fq[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (fifo_pop) begin
      chk("pop_spacing", 32'(cyc - last_pop >= 3), 1);
      last_pop = cyc;
      pops++;
      pop_times.push_back(cyc);
    end
    if (tx_valid) vcnt++;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) chk("sb_extra", 32'(exp_q.size()), 1);
      else chk("sb_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic push(input logic [7:0] b, input bit expect_tx);
    fq.push_back(b);
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic wait_done(input string tag);
    int n;
    repeat (4) @(posedge clk);
    for (n = 0; n < 300 && busy; n++) @(posedge clk);
    #1 chk(tag, 32'(busy), 0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    @(negedge clk);
    for (n = 0; n < 100 && !tx_valid; n++) @(negedge clk);
    chk(tag, 32'(tx_valid), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pop", 32'(fifo_pop), 0);
    chk("rst_cnt", 32'(sent_count), 0);
    chk("rst_data", 32'(tx_data), 0);
    @(posedge clk) #1 rst_n = 1'b1;

    // single byte
    enable = 1'b1; tx_ready = 1'b1;
    p0 = pops; v0 = vcnt;
    push(8'hA5, 1);
    wait_done("t1_done");
    chk("t1_cnt", 32'(sent_count), 1);
    chk("t1_pops", 32'(pops - p0), 1);
    chk("t1_vcyc", 32'(vcnt - v0), 1);

    // four bytes back to back
    pop_times.delete();
    for (int i = 1; i <= 4; i++) push(8'(i), 1);
    wait_done("t2_done");
    chk("t2_npops", 32'(pop_times.size()), 4);
    for (int i = 1; i < pop_times.size(); i++)
      chk("t2_gap", 32'(pop_times[i] - pop_times[i-1]), 4);
    chk("t2_cnt", 32'(sent_count), 5);

    // transmitter stall
    @(posedge clk) #1 tx_ready = 1'b0;
    p0 = pops;
    push(8'h3C, 1); push(8'h3D, 1);
    wait_valid("t3_valid");
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_v", 32'(tx_valid), 1);
      chk("t3_hold_d", 32'(tx_data), 32'h3C);
      @(negedge clk);
    end
    chk("t3_pops", 32'(pops - p0), 1);
    @(posedge clk) #1 tx_ready = 1'b1;
    wait_done("t3_done");
    chk("t3_cnt", 32'(sent_count), 7);

    // flush, flush also wins over enable for the second pair
    @(posedge clk) #1 enable = 1'b0; flush = 1'b1;
    p0 = pops; v0 = vcnt;
    push(8'hE1, 0); push(8'hE2, 0); push(8'hE3, 0);
    wait_done("t4_done");
    chk("t4_pops", 32'(pops - p0), 3);
    chk("t4_vcyc", 32'(vcnt - v0), 0);
    chk("t4_cnt", 32'(sent_count), 7);
    chk("t4_fifo", 32'(fq.size()), 0);
    @(posedge clk) #1 enable = 1'b1;
    p0 = pops; v0 = vcnt;
    push(8'hF1, 0); push(8'hF2, 0);
    wait_done("t4b_done");
    chk("t4b_pops", 32'(pops - p0), 2);
    chk("t4b_vcyc", 32'(vcnt - v0), 0);
    @(posedge clk) #1 flush = 1'b0; tx_ready = 1'b0;

    // enable dropped while byte 2 of 5 is held
    for (int i = 0; i < 5; i++) push(8'h51 + 8'(i), 1);
    wait_valid("t5_v1");
    @(posedge clk) #1 tx_ready = 1'b1;
    @(posedge clk) #1 tx_ready = 1'b0;
    wait_valid("t5_v2");
    @(posedge clk) #1 tx_ready = 1'b1; enable = 1'b0;
    @(posedge clk) #1 tx_ready = 1'b0;
    wait_done("t5_stop");
    chk("t5_left", 32'(fq.size()), 3);
    chk("t5_cnt2", 32'(sent_count), 9);
    @(posedge clk) #1 enable = 1'b1; tx_ready = 1'b1;
    wait_done("t5_done");
    chk("t5_cnt5", 32'(sent_count), 12);

    // async reset between edges while in SEND
    @(posedge clk) #1 tx_ready = 1'b0;
    push(8'h77, 1);
    wait_valid("t6_valid");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(tx_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cnt", 32'(sent_count), 0);
    exp_q.delete();
    push(8'h88, 1);
    pop_times.delete();
    @(posedge clk) #1 rst_n = 1'b1; tx_ready = 1'b1;
    c_rel = cyc;
    wait_done("t6_done");
    chk("t6_npops", 32'(pop_times.size()), 1);
    if (pop_times.size() != 0) chk("t6_first_pop", 32'(pop_times[0] - c_rel), 3);
    chk("t6_cnt1", 32'(sent_count), 1);
    chk("sb_left", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
